// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder: size codes, FSM states,
// the latched-request payload and the lane/extension functions.
package data_mem_responder_pkg;

   localparam int unsigned MEM_WORDS_DEF = 256;
   localparam int unsigned ADDR_W        = 16;
   localparam int unsigned DATA_W        = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Only what the READ cycle needs; stores complete on the accept edge.
   typedef struct packed {
      size_e      size;
      logic       sgn;
      logic [1:0] lane;
   } req_t;

   function automatic logic access_bad(size_e sz, logic [1:0] lane);
      case (sz)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lane[0];
         SZ_WORD: return lane != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] store_be(size_e sz, logic [1:0] lane);
      case (sz)
         SZ_BYTE: return 4'b0001 << lane;
         SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] store_data(size_e sz, logic [DATA_W-1:0] w);
      case (sz)
         SZ_BYTE: return {4{w[7:0]}};
         SZ_HALF: return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] load_extend(logic [DATA_W-1:0] w, size_e sz,
                                                     logic sgn, logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {lane, 3'b000});
      h = 16'(w >> {lane[1], 4'b0000});
      case (sz)
         SZ_BYTE: return sgn ? {{24{b[7]}}, b} : {24'd0, b};
         SZ_HALF: return sgn ? {{16{h[15]}}, h} : {16'd0, h};
         SZ_WORD: return w;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory responder.
interface data_mem_responder_if;
   import data_mem_responder_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder_dmem_bank.sv
// Synchronous 32-bit RAM with per-byte write enable and one-cycle registered read.
module dmem_bank #(
   parameter int unsigned WORDS = 256,
   parameter int unsigned AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: alignment check, byte-lane write,
// lane select plus sign/zero extension on loads.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   data_mem_responder_if.slave  bus
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   state_e      state, state_n;
   req_t        req_q;
   size_e       size_c;
   logic        bad_c;
   logic        accept_c;
   logic [3:0]  ram_we_c;
   logic [31:0] ram_rdata;
   logic        ready_q, resp_valid_q, err_q;
   logic [31:0] rdata_q;
   logic        err_n;
   logic [31:0] rdata_n;
   logic        unused_addr;

   assign size_c   = size_e'(bus.req_size);
   assign bad_c    = access_bad(size_c, bus.req_addr[1:0]);
   assign accept_c = (state == ST_IDLE) && bus.req_valid;

   // Stores land on the accept edge; a reset edge suppresses the write.
   assign ram_we_c = (accept_c && bus.req_wen && !bad_c && resetn)
                     ? store_be(size_c, bus.req_addr[1:0]) : 4'b0000;

   // Upper address bits wrap away by design.
   assign unused_addr = ^bus.req_addr[ADDR_W-1:AW+2];

   dmem_bank #(.WORDS(MEM_WORDS), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (ram_we_c),
      .addr  (bus.req_addr[AW+1:2]),
      .wdata (store_data(size_c, bus.req_wdata)),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state        <= state_n;
         ready_q      <= (state_n == ST_IDLE);
         resp_valid_q <= (state_n == ST_RESP);
         err_q        <= err_n;
         rdata_q      <= rdata_n;
         if (accept_c) req_q <= '{size: size_c, sgn: bus.req_signed, lane: bus.req_addr[1:0]};
      end
   end

   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      rdata_n = '0;
      case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (!bus.req_wen && !bad_c) begin
                  state_n = ST_READ;
               end else begin
                  state_n = ST_RESP;
                  err_n   = bad_c;
               end
            end
         end
         ST_READ: begin
            state_n = ST_RESP;
            rdata_n = load_extend(ram_rdata, req_q.size, req_q.sgn, req_q.lane);
         end
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = err_q;
   assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

   logic clk;
   logic resetn;
   int   total = 0;
   int   bad   = 0;

   data_mem_responder_if bus ();

   data_mem_responder #(.MEM_WORDS(256)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request; report latency (1 = cycle after accept) and response fields.
   task automatic do_req(input logic wen, input logic [1:0] sz, input logic sg,
                         input logic [15:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
      int n;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_size = sz;
      bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 0; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 6; k++) begin
         if (bus.resp_valid === 1'b1) begin
            lat = k; rd = bus.resp_rdata; er = bus.resp_err;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0;
      bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.resp_valid); end
      total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.resp_err); end
      total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_word();
      int lat; logic [31:0] rd; logic er;
      do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, lat, rd, er);
      total++; if (lat != 1) begin bad++; $display("FAIL sw_latency got=%0d exp=1", lat); end
      total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_resp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
      do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, lat, rd, er);
      total++; if (lat != 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
      total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", rd, er); end
   endtask

   task automatic test_byte();
      int lat; logic [31:0] rd; logic er;
      do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h00000000, lat, rd, er);
      do_req(1'b1, 2'd0, 1'b0, 16'h0013, 32'hFFFFFF80, lat, rd, er);
      total++; if (lat != 1 || er !== 1'b0) begin bad++; $display("FAIL sb_resp got lat=%0d err=%b exp lat=1 err=0", lat, er); end
      do_req(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, lat, rd, er);
      total++; if (rd !== 32'hFFFFFF80 || lat != 2) begin bad++; $display("FAIL lb got=%h lat=%0d exp=ffffff80 lat=2", rd, lat); end
      do_req(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, lat, rd, er);
      total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", rd); end
      do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, lat, rd, er);
      total++; if (rd !== 32'h80000000) begin bad++; $display("FAIL lw_after_sb got=%h exp=80000000", rd); end
   endtask

   task automatic test_half();
      int lat; logic [31:0] rd; logic er;
      do_req(1'b1, 2'd2, 1'b0, 16'h0020, 32'hAAAA5555, lat, rd, er);
      do_req(1'b1, 2'd1, 1'b0, 16'h0022, 32'h00001234, lat, rd, er);
      do_req(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, lat, rd, er);
      total++; if (rd !== 32'h12345555) begin bad++; $display("FAIL lw_after_sh got=%h exp=12345555", rd); end
      do_req(1'b1, 2'd2, 1'b0, 16'h0024, 32'hCAFE8001, lat, rd, er);
      do_req(1'b0, 2'd1, 1'b1, 16'h0024, 32'h0, lat, rd, er);
      total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%h exp=ffff8001", rd); end
      do_req(1'b0, 2'd1, 1'b0, 16'h0026, 32'h0, lat, rd, er);
      total++; if (rd !== 32'h0000CAFE) begin bad++; $display("FAIL lhu got=%h exp=0000cafe", rd); end
      do_req(1'b0, 2'd1, 1'b1, 16'h0026, 32'h0, lat, rd, er);
      total++; if (rd !== 32'hFFFFCAFE) begin bad++; $display("FAIL lh_upper got=%h exp=ffffcafe", rd); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic er;
      do_req(1'b1, 2'd2, 1'b0, 16'h0012, 32'h11111111, lat, rd, er);
      total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL err_sw_mis got err=%b rdata=%h lat=%0d exp 1/0/1", er, rd, lat); end
      do_req(1'b0, 2'd1, 1'b1, 16'h0011, 32'h0, lat, rd, er);
      total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL err_lh_mis got err=%b rdata=%h lat=%0d exp 1/0/1", er, rd, lat); end
      do_req(1'b1, 2'd3, 1'b0, 16'h0010, 32'hFFFFFFFF, lat, rd, er);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_size3 got err=%b rdata=%h exp 1/0", er, rd); end
      do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, lat, rd, er);
      total++; if (rd !== 32'h80000000 || er !== 1'b0) begin bad++; $display("FAIL err_mem_kept got=%h err=%b exp=80000000 err=0", rd, er); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic er;
      int seen;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_size = 2'd2; bus.req_addr = 16'h0010;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      // Store presented while reset is asserted must not write.
      bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = 2'd2;
      bus.req_addr = 16'h0010; bus.req_wdata = 32'hFFFFFFFF;
      seen = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid === 1'b1) seen++;
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      if (bus.resp_valid === 1'b1) seen++;
      total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_noresp got=%0d exp=0", seen); end
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", bus.req_ready); end
      do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, lat, rd, er);
      total++; if (rd !== 32'h80000000) begin bad++; $display("FAIL rst_store_blocked got=%h exp=80000000", rd); end
   endtask

   task automatic test_wrap_back_to_back();
      int lat; logic [31:0] rd; logic er;
      int pulses, first, both, leak;
      do_req(1'b1, 2'd2, 1'b0, 16'h0400, 32'h5A5AA5A5, lat, rd, er);
      do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, lat, rd, er);
      total++; if (rd !== 32'h5A5AA5A5) begin bad++; $display("FAIL wrap got=%h exp=5a5aa5a5", rd); end
      @(negedge clk);
      while (bus.req_ready !== 1'b1) @(negedge clk);
      bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_size = 2'd2; bus.req_addr = 16'h0000;
      pulses = 0; first = 0; both = 0; leak = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
            if (bus.resp_rdata !== 32'h5A5AA5A5) leak++;
            if (bus.req_ready === 1'b1) both++;
         end else if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            leak++;
         end
      end
      bus.req_valid = 1'b0;
      total++; if (pulses != 4) begin bad++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
      total++; if (first != 2) begin bad++; $display("FAIL b2b_first got=%0d exp=2", first); end
      total++; if (both != 0) begin bad++; $display("FAIL b2b_ready_in_resp got=%0d exp=0", both); end
      total++; if (leak != 0) begin bad++; $display("FAIL b2b_idle_zero got=%0d exp=0", leak); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_reset_mid();
      test_wrap_back_to_back();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
